// File: rtl/rsp_fifo.sv
// rsp_fifo: first-word-fall-through response FIFO
// between the command engine and uart_tx.
package rsp_fifo_pkg;

  typedef struct packed {
    logic [7:0] cmd_type;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_packet_t;

endpackage

module rsp_fifo
  import rsp_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  cmd_packet_t      wr_data,
  output logic             full,
  input  logic             data_read_en,
  output cmd_packet_t      cmd_rsp,
  output logic             data_ready,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int PTR_W = $clog2(DEPTH);

  cmd_packet_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             push_ok;
  logic             pop_ok;
  logic             ovf_ev;
  logic             udf_ev;

  // Flags come straight from the registered count.
  assign full       = (cnt_q == CNT_W'(DEPTH));
  assign data_ready = (cnt_q != '0);
  assign count      = cnt_q;

  // A pop frees the slot a push needs when full.
  assign push_ok = wr_en & (~full | data_read_en);
  assign pop_ok  = data_read_en & data_ready;
  assign ovf_ev  = wr_en & full & ~data_read_en;
  assign udf_ev  = data_read_en & ~data_ready;

  // Head is visible with no read latency.
  assign cmd_rsp = mem[rd_ptr];

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Next occupancy from accepted push/pop.
  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      push_ok & ~pop_ok: cnt_d = cnt_q + CNT_W'(1);
      pop_ok & ~push_ok: cnt_d = cnt_q - CNT_W'(1);
      default:           cnt_d = cnt_q;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Sticky errors; a fresh event beats clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_ev) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (udf_ev) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule
